player_phase: RTL and testbench
===============================

PLAYER_PHASE -- requirements
Module: player_phase

Interface
REQ-001 SHALL have parameter PHASE_CODE, default 4'b0001, the state_in value that activates this phase.
REQ-002 SHALL have parameter MOVE_STEP, default 8, cursor pixels moved per rotate step.
REQ-003 SHALL have parameter SHOT_SPEED, default 16, projectile pixels moved per frame.
REQ-004 SHALL have port clk  input  1  system clock, single clock domain.
REQ-005 SHALL have port rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-006 SHALL have port hcount_in  input  11  current pixel column, 0..1649, visible 0..1279.
REQ-007 SHALL have port vcount_in  input  10  current pixel row, 0..749, visible 0..719.
REQ-008 SHALL have port state_in  input  4  phase code from the game sequencer.
REQ-009 SHALL have port rotate_in  input  2  01=step right, 10=step left, 11=fire, 00=none; level input.
REQ-010 SHALL have port busy_out  output  1  high while the phase is running.
REQ-011 SHALL have port finished_out  output  1  high once the phase completes, held until deactivation.
REQ-012 SHALL have port pixel_out  output  12  RGB444 colour for (hcount_in, vcount_in).

Function
REQ-013 SHALL generate frame_tick as a one-cycle pulse when hcount_in==0 and vcount_in==720.
REQ-014 SHALL implement the FSM states IDLE, AIM, FLIGHT and DONE.
REQ-015 IDLE->AIM SHALL occur on the first cycle state_in==PHASE_CODE, loading cursor_x=608, shot_y=640, with busy_out=1 from the next cycle.
REQ-016 In AIM, each rising edge of rotate_in to 01 or 10 SHALL move cursor_x by ±MOVE_STEP, saturating at 0 and 1216 (64-pixel sprite); a held level SHALL produce one step only.
REQ-017 In AIM, a rising edge to 11 SHALL latch shot_x=cursor_x+28 and enter FLIGHT.
REQ-018 In FLIGHT, each frame_tick SHALL subtract SHOT_SPEED from shot_y; when shot_y<SHOT_SPEED before the subtract, the FSM SHALL enter DONE (no wrap-around).
REQ-019 In DONE, busy_out SHALL be 0 and finished_out SHALL be 1, held while state_in==PHASE_CODE.
REQ-020 In any non-IDLE state, state_in!=PHASE_CODE SHALL return the FSM to IDLE next cycle with busy_out=0 and finished_out=0 (abort).
REQ-021 A simultaneous fire edge and state_in change SHALL resolve to the abort.
REQ-022 pixel_out SHALL be registered with 1-cycle latency: 8-pixel projectile 12'hFF0 during FLIGHT; cursor sprite 12'h0F0 when rows 656..719 overlap cursor_x..cursor_x+63; otherwise 12'h000.
REQ-023 The projectile SHALL take priority over the cursor; pixel_out SHALL be 12'h000 in IDLE and outside the visible area.

Reset
REQ-024 rst_n==0 SHALL force IDLE, busy_out=0, finished_out=0, pixel_out=0, cursor_x=608, shot_y=640, and clear the rotate edge history, on the next clock edge.
REQ-025 A reset mid-FLIGHT SHALL discard the shot; the phase restarts only via REQ-015.

Configuration
REQ-026 With PLAYER_TIMEOUT_EN defined, AIM SHALL count frame_ticks and auto-fire at the current cursor_x after 600 frames (10 s); the counter SHALL clear on entry to AIM.
REQ-027 With PLAYER_TIMEOUT_EN undefined, no timeout counter SHALL exist and AIM SHALL wait indefinitely.

Structure
REQ-028 The shared package game_pkg SHALL hold phase-code constants (MENU=0000, PLAYER=0001, ENEMY=1000), the screen limits (1280, 720), the colour constants and the phase FSM state typedef.
REQ-029 A sub-module rect_sprite (x, y, w, h, colour in; hit and colour out) SHALL render both the cursor and the projectile.

Verification
REQ-030 Bench SHALL cover: state_in=0001 after reset -> busy_out=1 two cycles later, finished_out=0, cursor_x=608.
REQ-031 Bench SHALL cover: three rotate 01 pulses -> cursor_x=632; rotate held at 01 for 100 cycles -> exactly one step.
REQ-032 Bench SHALL cover: 200 steps left -> cursor_x saturates at 0 with no underflow.
REQ-033 Bench SHALL cover: fire at cursor_x=608 -> shot_x=636; FLIGHT lasts 40 frames with SHOT_SPEED=16; then finished_out=1 and busy_out=0.
REQ-034 Bench SHALL cover: state_in->1000 during FLIGHT -> IDLE next cycle, both flags 0, pixel_out=0.
REQ-035 Bench SHALL cover: with PLAYER_TIMEOUT_EN, no input for 600 frames -> auto-fire at cursor_x=608.

Source files
------------

// File: rtl/game_pkg.sv
// ============================================================================
// game_pkg : phase codes, screen limits, colours and phase FSM state type
// Rev 1.0
// ============================================================================
`default_nettype none

package game_pkg;

  localparam logic [3:0]  PHASE_MENU   = 4'b0000;
  localparam logic [3:0]  PHASE_PLAYER = 4'b0001;
  localparam logic [3:0]  PHASE_ENEMY  = 4'b1000;

  localparam logic [10:0] SCREEN_W     = 11'd1280;
  localparam logic [9:0]  SCREEN_H     = 10'd720;

  localparam logic [11:0] COLOUR_BLACK  = 12'h000;
  localparam logic [11:0] COLOUR_CURSOR = 12'h0F0;
  localparam logic [11:0] COLOUR_SHOT   = 12'hFF0;

  localparam logic [10:0] CURSOR_W       = 11'd64;
  localparam logic [9:0]  CURSOR_H       = 10'd64;
  localparam logic [9:0]  CURSOR_Y       = 10'd656;
  localparam logic [10:0] CURSOR_START_X = 11'd608;
  localparam logic [10:0] CURSOR_MAX_X   = 11'd1216;
  localparam logic [9:0]  SHOT_START_Y   = 10'd640;
  localparam logic [10:0] SHOT_W         = 11'd8;
  localparam logic [9:0]  SHOT_H         = 10'd8;
  localparam logic [10:0] SHOT_X_OFFSET  = 11'd28;

  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_AIM    = 2'd1,
    PH_FLIGHT = 2'd2,
    PH_DONE   = 2'd3
  } phase_state_e;

endpackage

`default_nettype wire

// File: rtl/rect_sprite.sv
// ============================================================================
// rect_sprite : solid axis-aligned rectangle hit test for the current pixel
// Rev 1.0
// ============================================================================
`default_nettype none

module rect_sprite (
  input  logic [10:0] x_in,
  input  logic [9:0]  y_in,
  input  logic [10:0] w_in,
  input  logic [9:0]  h_in,
  input  logic [11:0] colour_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  output logic        hit_out,
  output logic [11:0] colour_out
);

  logic [11:0] x_end;
  logic [10:0] y_end;

  always_comb begin
    x_end      = {1'b0, x_in} + {1'b0, w_in};
    y_end      = {1'b0, y_in} + {1'b0, h_in};
    hit_out    = (hcount_in >= x_in) && ({1'b0, hcount_in} < x_end) &&
                 (vcount_in >= y_in) && ({1'b0, vcount_in} < y_end);
    colour_out = hit_out ? colour_in : 12'h000;
  end

endmodule

`default_nettype wire

// File: rtl/player_phase.sv
// ============================================================================
// player_phase : aim a cursor, fire a projectile, report completion.
// Optional PLAYER_TIMEOUT_EN auto-fires after 600 frames in AIM.  Rev 1.0
// ============================================================================
`default_nettype none

module player_phase
  import game_pkg::*;
#(
  parameter logic [3:0] PHASE_CODE = 4'b0001,
  parameter int         MOVE_STEP  = 8,
  parameter int         SHOT_SPEED = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic [3:0]  state_in,
  input  logic [1:0]  rotate_in,
  output logic        busy_out,
  output logic        finished_out,
  output logic [11:0] pixel_out
);

  localparam logic [10:0] STEP_X  = 11'(MOVE_STEP);
  localparam logic [9:0]  SPEED_Y = 10'(SHOT_SPEED);

  phase_state_e state_q, state_d;
  logic [10:0]  cursor_x_q, cursor_x_d;
  logic [10:0]  shot_x_q, shot_x_d;
  logic [9:0]   shot_y_q, shot_y_d;
  logic [1:0]   rot_prev_q, rot_prev_d;
  logic         busy_q, busy_d;
  logic         finished_q, finished_d;
  logic [11:0]  pixel_q, pixel_d;
`ifdef PLAYER_TIMEOUT_EN
  logic [9:0]   timer_q, timer_d;
`endif

  logic        frame_tick, active, rot_edge, fire, auto_fire, visible;
  logic        cursor_hit, shot_hit;
  logic [11:0] cursor_colour, shot_colour;

  rect_sprite u_cursor (
    .x_in(cursor_x_q), .y_in(CURSOR_Y), .w_in(CURSOR_W), .h_in(CURSOR_H),
    .colour_in(COLOUR_CURSOR), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hit_out(cursor_hit), .colour_out(cursor_colour)
  );

  rect_sprite u_shot (
    .x_in(shot_x_q), .y_in(shot_y_q), .w_in(SHOT_W), .h_in(SHOT_H),
    .colour_in(COLOUR_SHOT), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hit_out(shot_hit), .colour_out(shot_colour)
  );

  always_comb begin
    frame_tick = (hcount_in == 11'd0) && (vcount_in == 10'd720);
    active     = (state_in == PHASE_CODE);
    rot_edge   = (rotate_in != rot_prev_q);
    fire       = rot_edge && (rotate_in == 2'b11);
    auto_fire  = 1'b0;
    visible    = (hcount_in < SCREEN_W) && (vcount_in < SCREEN_H);

    state_d    = state_q;
    cursor_x_d = cursor_x_q;
    shot_x_d   = shot_x_q;
    shot_y_d   = shot_y_q;
    rot_prev_d = rotate_in;
`ifdef PLAYER_TIMEOUT_EN
    timer_d    = timer_q;
`endif

    case (state_q)
      PH_IDLE: begin
        if (active) begin
          state_d    = PH_AIM;
          cursor_x_d = CURSOR_START_X;
          shot_y_d   = SHOT_START_Y;
`ifdef PLAYER_TIMEOUT_EN
          timer_d    = 10'd0;
`endif
        end
      end
      PH_AIM: begin
`ifdef PLAYER_TIMEOUT_EN
        if (frame_tick) begin
          timer_d   = timer_q + 10'd1;
          auto_fire = (timer_q == 10'd599);
        end
`endif
        if (fire || auto_fire) begin
          shot_x_d = cursor_x_q + SHOT_X_OFFSET;
          state_d  = PH_FLIGHT;
        end else if (rot_edge && rotate_in == 2'b01) begin
          cursor_x_d = (cursor_x_q > CURSOR_MAX_X - STEP_X) ? CURSOR_MAX_X
                                                             : cursor_x_q + STEP_X;
        end else if (rot_edge && rotate_in == 2'b10) begin
          cursor_x_d = (cursor_x_q < STEP_X) ? 11'd0 : cursor_x_q - STEP_X;
        end
      end
      PH_FLIGHT: begin
        // Compare before subtracting so the shot never wraps past the top
        if (frame_tick) begin
          if (shot_y_q < SPEED_Y) state_d  = PH_DONE;
          else                    shot_y_d = shot_y_q - SPEED_Y;
        end
      end
      default: ;
    endcase

    // Losing the phase code beats any same-cycle fire or move
    if (state_q != PH_IDLE && !active) state_d = PH_IDLE;

    busy_d     = (state_d == PH_AIM) || (state_d == PH_FLIGHT);
    finished_d = (state_d == PH_DONE);

    pixel_d = COLOUR_BLACK;
    if (state_q != PH_IDLE && visible) begin
      if (state_q == PH_FLIGHT && shot_hit) pixel_d = shot_colour;
      else if (cursor_hit)                  pixel_d = cursor_colour;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= PH_IDLE;
      cursor_x_q <= CURSOR_START_X;
      shot_x_q   <= 11'd0;
      shot_y_q   <= SHOT_START_Y;
      rot_prev_q <= 2'b00;
      busy_q     <= 1'b0;
      finished_q <= 1'b0;
      pixel_q    <= COLOUR_BLACK;
`ifdef PLAYER_TIMEOUT_EN
      timer_q    <= 10'd0;
`endif
    end else begin
      state_q    <= state_d;
      cursor_x_q <= cursor_x_d;
      shot_x_q   <= shot_x_d;
      shot_y_q   <= shot_y_d;
      rot_prev_q <= rot_prev_d;
      busy_q     <= busy_d;
      finished_q <= finished_d;
      pixel_q    <= pixel_d;
`ifdef PLAYER_TIMEOUT_EN
      timer_q    <= timer_d;
`endif
    end
  end

  assign busy_out     = busy_q;
  assign finished_out = finished_q;
  assign pixel_out    = pixel_q;

endmodule

`default_nettype wire

// File: tb/tb_player_phase.sv
// ============================================================================
// tb_player_phase : directed scenarios plus random traffic against a
// behavioural model of the player phase.  Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_player_phase;

  localparam logic [3:0] CODE  = 4'b0001;
  localparam logic [3:0] ENEMY = 4'b1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [3:0]  state_in;
  logic [1:0]  rotate;
  logic        busy, finished;
  logic [11:0] pixel;

  always #5 clk = ~clk;

  player_phase dut (
    .clk(clk), .rst_n(rst_n), .hcount_in(hcount), .vcount_in(vcount),
    .state_in(state_in), .rotate_in(rotate), .busy_out(busy),
    .finished_out(finished), .pixel_out(pixel)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: 0 idle, 1 aiming, 2 shot in flight, 3 finished
  int m_state, m_cx, m_sx, m_sy, m_prev, m_frames;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int model_pixel(int h, int v);
    if (m_state == 0 || h >= 1280 || v >= 720) return 'h000;
    if (m_state == 2 && h >= m_sx && h < m_sx + 8 && v >= m_sy && v < m_sy + 8) return 'hFF0;
    if (v >= 656 && v < 720 && h >= m_cx && h < m_cx + 64) return 'h0F0;
    return 'h000;
  endfunction

  task automatic model_update(input int rot, input logic [3:0] st, input int h, input int v);
    bit tick, rise, shoot;
    tick  = (h == 0 && v == 720);
    rise  = (rot != m_prev);
    shoot = 1'b0;
    if (!rst_n) begin
      m_state = 0; m_cx = 608; m_sy = 640; m_prev = 0; m_frames = 0;
      return;
    end
    if (m_state != 0 && st != CODE) m_state = 0;
    else begin
      case (m_state)
        0: if (st == CODE) begin m_state = 1; m_cx = 608; m_sy = 640; m_frames = 0; end
        1: begin
          shoot = rise && rot == 3;
`ifdef PLAYER_TIMEOUT_EN
          if (tick) begin
            m_frames++;
            if (m_frames == 600) shoot = 1'b1;
          end
`endif
          if (shoot) begin m_sx = m_cx + 28; m_state = 2; end
          else if (rise && rot == 1) m_cx = (m_cx + 8 > 1216) ? 1216 : m_cx + 8;
          else if (rise && rot == 2) m_cx = (m_cx < 8) ? 0 : m_cx - 8;
        end
        2: if (tick) begin
          if (m_sy < 16) m_state = 3;
          else m_sy -= 16;
        end
        default: ;
      endcase
    end
    m_prev = rot;
  endtask

  task automatic step(input logic [1:0] rot, input logic [3:0] st, input int h, input int v);
    int exp_pix;
    rotate = rot; state_in = st; hcount = h[10:0]; vcount = v[9:0];
    exp_pix = rst_n ? model_pixel(h, v) : 0;
    @(posedge clk);
    model_update(int'(rot), st, h, v);
    @(negedge clk);
    check("busy", busy, (m_state == 1 || m_state == 2));
    check("finished", finished, (m_state == 3));
    check("pixel", pixel, exp_pix);
  endtask

  task automatic rand_hv(output int h, output int v);
    h = $urandom_range(0, 1649);
    v = $urandom_range(0, 749);
    if (h == 0 && v == 720) v = 0;
  endtask

  task automatic step_r(input logic [1:0] rot, input logic [3:0] st);
    int h, v;
    rand_hv(h, v);
    step(rot, st, h, v);
  endtask

  task automatic frame(input logic [1:0] rot, input logic [3:0] st);
    step_r(rot, st);
    step(rot, st, 0, 720);
  endtask

  task automatic probe_cursor(input logic [1:0] rot, input int x);
    step(rot, CODE, x, 700);      check("cur_first_col", pixel, 12'h0F0);
    if (x > 0) begin
      step(rot, CODE, x - 1, 700); check("cur_before", pixel, 12'h000);
    end
    step(rot, CODE, x + 63, 700); check("cur_last_col", pixel, 12'h0F0);
    step(rot, CODE, x + 64, 700); check("cur_after", pixel, 12'h000);
  endtask

  initial begin
    rst_n = 1'b0; rotate = 2'b00; state_in = 4'b0000; hcount = '0; vcount = '0;
    m_state = 0; m_cx = 608; m_sy = 640; m_sx = 0; m_prev = 0; m_frames = 0;
    @(negedge clk);

    repeat (3) step_r(2'b00, CODE);
    check("rst_busy", busy, 0);
    check("rst_finished", finished, 0);
    check("rst_pixel", pixel, 12'h000);
    rst_n = 1'b1;

    step_r(2'b00, CODE);
    step_r(2'b00, CODE);
    check("enter_busy", busy, 1);
    check("enter_finished", finished, 0);
    probe_cursor(2'b00, 608);

    repeat (3) begin step_r(2'b01, CODE); step_r(2'b00, CODE); end
    probe_cursor(2'b00, 632);
    repeat (100) step_r(2'b01, CODE);
    probe_cursor(2'b01, 640);
    step_r(2'b00, CODE);

    repeat (200) begin step_r(2'b10, CODE); step_r(2'b00, CODE); end
    probe_cursor(2'b00, 0);

    // Restart and fire from the centre
    step_r(2'b00, ENEMY);
    check("abort_aim_busy", busy, 0);
    step_r(2'b00, CODE);
    step_r(2'b00, CODE);
    probe_cursor(2'b00, 608);
    step_r(2'b11, CODE);
    step(2'b11, CODE, 636, 640); check("shot_left", pixel, 12'hFF0);
    step(2'b11, CODE, 635, 640); check("shot_before", pixel, 12'h000);
    step(2'b11, CODE, 643, 647); check("shot_corner", pixel, 12'hFF0);
    step(2'b11, CODE, 644, 640); check("shot_after", pixel, 12'h000);
    step(2'b11, CODE, 636, 648); check("shot_below", pixel, 12'h000);
    repeat (40) frame(2'b00, CODE);
    check("flight40_busy", busy, 1);
    check("flight40_finished", finished, 0);
    frame(2'b00, CODE);
    check("done_finished", finished, 1);
    check("done_busy", busy, 0);
    repeat (5) step_r(2'b00, CODE);
    check("done_held", finished, 1);

    // Abort mid-flight
    step_r(2'b00, 4'b0000);
    check("done_abort_fin", finished, 0);
    step_r(2'b00, CODE);
    step_r(2'b11, CODE);
    frame(2'b00, CODE);
    step(2'b00, ENEMY, 636, 624);
    check("fabort_busy", busy, 0);
    check("fabort_finished", finished, 0);
    step(2'b00, ENEMY, 636, 624);
    check("fabort_pixel", pixel, 12'h000);

    // Fire edge coinciding with loss of phase code
    step_r(2'b00, CODE);
    step_r(2'b00, CODE);
    step_r(2'b11, ENEMY);
    check("fire_abort_busy", busy, 0);
    step_r(2'b11, ENEMY);
    check("fire_abort_fin", finished, 0);

    // Reset mid-flight discards the shot
    step_r(2'b00, CODE);
    step_r(2'b11, CODE);
    frame(2'b00, CODE);
    rst_n = 1'b0;
    step_r(2'b00, CODE);
    check("rstfl_busy", busy, 0);
    rst_n = 1'b1;
    step_r(2'b00, CODE);
    step_r(2'b00, CODE);
    check("rstfl_reenter", busy, 1);
    probe_cursor(2'b00, 608);
    step(2'b00, CODE, 636, 624);
    check("rstfl_noshot", pixel, 12'h000);

`ifdef PLAYER_TIMEOUT_EN
    step_r(2'b00, 4'b0000);
    step_r(2'b00, CODE);
    step_r(2'b00, CODE);
    repeat (599) frame(2'b00, CODE);
    step(2'b00, CODE, 636, 640);
    check("to_wait_pixel", pixel, 12'h000);
    check("to_wait_busy", busy, 1);
    frame(2'b00, CODE);
    step(2'b00, CODE, 636, 640);
    check("to_fire_pixel", pixel, 12'hFF0);
`endif

    for (int i = 0; i < 2000; i++) begin
      logic [1:0] r;
      logic [3:0] s;
      int h, v;
      r = 2'($urandom_range(0, 3));
      s = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(0, 15)) : CODE;
      rst_n = ($urandom_range(0, 99) != 0);
      case ($urandom_range(0, 3))
        0: begin h = 0; v = 720; end
        1: begin h = $urandom_range(500, 760); v = $urandom_range(600, 725); end
        default: rand_hv(h, v);
      endcase
      step(r, s, h, v);
    end
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
